edac_encode_4bit: RTL
=====================

Name: edac_encode_4bit

Overview:
- Write-side companion of the 4-bit EDAC decoder. Takes a 4-bit data nibble and an 8-bit CRC polynomial, and produces the 16-bit protected codeword.
- Codeword layout: upper byte is a Hamming(7,4) byte, lower byte is the CRC remainder. The decoder's syndrome check and CRC check both pass on this word.
- The CRC is computed serially, one bit per clock. The block issues a one-cycle write strobe so the codeword can be stored in the lookup table the decoder compares against.

Parameters:
- ERR_WORD, 16'hFFFF, codeword driven when the request is rejected.
- CRC_STEPS, 8, number of serial CRC division steps; fixed by the codeword format.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  block enable; gates request acceptance only.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- din  in  4  data nibble, d3..d0.
- crc_poly  in  8  CRC polynomial; bit 7 is the leading term.
- out_valid  out  1  codeword available.
- out_ready  in  1  consumer accepts the codeword.
- dout  out  16  codeword; also the lookup-table write data.
- err  out  1  dout is ERR_WORD because the polynomial was rejected.
- lut_wr  out  1  one-cycle lookup-table write strobe.

Behaviour:
- Reset values: in_ready=0, out_valid=0, dout=16'h0000, err=0, lut_wr=0, FSM=IDLE, step counter=0.
- Reset is asynchronous and may arrive mid-operation. It aborts the operation: no out_valid and no lut_wr are produced.
- FSM states: IDLE, HAM, CRC, DONE.
- IDLE: in_ready = en. The request is accepted on the edge where in_valid && in_ready; din and crc_poly are registered on that edge.
  - If crc_poly[7]=1, go to HAM.
  - If crc_poly[7]=0, go to DONE with dout=ERR_WORD and err=1.
- HAM (1 cycle) builds upper byte U:
  - U[2]=d0, U[4]=d1, U[5]=d2, U[6]=d3.
  - U[0]=d0^d1^d3, U[1]=d0^d2^d3, U[3]=d1^d2^d3.
  - U[7]=0.
  - Load work={U,8'h00}, polyreg={crc_poly,8'h00}, counter=0, go to CRC.
- CRC (8 cycles). Step k=0..7:
  - If work[15-k]=1, work ^= polyreg.
  - Then polyreg >>= 1 and counter increments.
  - On the edge completing step 7: go to DONE and load dout={U, post-step work[7:0]}, err=0.
- Latency: accept edge T0, HAM edge T1, CRC edges T2..T9. out_valid is high from T9 onward, i.e. 9 cycles after acceptance.
- DONE: out_valid=1. dout and err are held stable until an edge with out_ready=1, which moves the FSM to IDLE and clears out_valid.
  - in_ready rises the following cycle; there is no same-cycle re-accept.
- lut_wr: high for exactly the first cycle of DONE, and only when err=0. It is not repeated while back-pressured.
- en=0 mid-operation does not abort; it only blocks the next acceptance.
- in_ready=0 outside IDLE; in_valid is ignored there.
- din and crc_poly changes after acceptance have no effect.
- dout keeps its last value in IDLE.

Test Plan:
- Basic encode: din=4'b1011, crc_poly=8'h87, out_ready=1.
  - Required: out_valid 9 cycles after accept, dout=16'h5544, err=0, lut_wr high for 1 cycle.
- Zero data: din=4'h0, crc_poly=8'h87 -> dout=16'h0000, err=0, lut_wr pulse.
- Rejected polynomial: din=4'hB, crc_poly=8'h07 -> out_valid on the cycle after accept, dout=16'hFFFF, err=1, lut_wr never asserted.
- Back-pressure: repeat the basic encode with out_ready=0 for 5 cycles after out_valid.
  - Required: dout=16'h5544 stable, out_valid held, lut_wr one pulse only, in_ready=0 until the cycle after the out_ready handshake.
- Reset mid-operation: assert rst_n=0 asynchronously during CRC step 4.
  - Required: outputs immediately at reset values, no out_valid or lut_wr afterwards.
  - A fresh request then yields the basic-encode result.
- Exhaustive sweep: all 16 din values with crc_poly=8'h87, plus back-to-back requests with in_valid held high.
  - Every dout has Hamming syndrome 0, bit 15=0, and a serial CRC residue of 0.
  - Consecutive accepts are spaced by at least 11 cycles when out_ready=1.

Source files
------------

// File: rtl/edac_encode_4bit.sv
// rtl/edac_encode_4bit.sv - Hamming(7,4) plus serial CRC codeword encoder for the 4-bit EDAC path
module edac_encode_4bit #(
    parameter logic [15:0] ERR_WORD  = 16'hFFFF,
    parameter int          CRC_STEPS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  din,
    input  logic [7:0]  crc_poly,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] dout,
    output logic        err,
    output logic        lut_wr
);

    localparam int CW = $clog2(CRC_STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HAM  = 2'd1,
        CRC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    din_q, din_d;
    logic [7:0]    poly_q, poly_d;
    logic [7:0]    u_q, u_d;
    logic [15:0]   work_q, work_d;
    logic [15:0]   polyreg_q, polyreg_d;
    logic [15:0]   dout_q, dout_d;
    logic          err_q, err_d;
    logic          lut_wr_q, lut_wr_d;

    logic [7:0]    ham_byte;
    logic [15:0]   work_step;
    logic [3:0]    lead_idx;

    // Hamming byte from the captured nibble: data at positions 3,5,6,7, parity at 1,2,4.
    always_comb begin
        ham_byte    = 8'h00;
        ham_byte[2] = din_q[0];
        ham_byte[4] = din_q[1];
        ham_byte[5] = din_q[2];
        ham_byte[6] = din_q[3];
        ham_byte[0] = din_q[0] ^ din_q[1] ^ din_q[3];
        ham_byte[1] = din_q[0] ^ din_q[2] ^ din_q[3];
        ham_byte[3] = din_q[1] ^ din_q[2] ^ din_q[3];
    end

    // One long-division step: subtract the aligned polynomial when the current leading bit is set.
    always_comb begin
        lead_idx  = 4'd15 - 4'(cnt_q);
        work_step = work_q;
        if (work_q[lead_idx]) begin
            work_step = work_q ^ polyreg_q;
        end
    end

    // Next-state and datapath updates for the encode sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        din_d     = din_q;
        poly_d    = poly_q;
        u_d       = u_q;
        work_d    = work_q;
        polyreg_d = polyreg_q;
        dout_d    = dout_q;
        err_d     = err_q;
        lut_wr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    din_d  = din;
                    poly_d = crc_poly;
                    if (crc_poly[7]) begin
                        state_d = HAM;
                    end else begin
                        state_d = DONE;
                        dout_d  = ERR_WORD;
                        err_d   = 1'b1;
                    end
                end
            end
            HAM: begin
                u_d       = ham_byte;
                work_d    = {ham_byte, 8'h00};
                polyreg_d = {poly_q, 8'h00};
                cnt_d     = '0;
                state_d   = CRC;
            end
            CRC: begin
                work_d    = work_step;
                polyreg_d = polyreg_q >> 1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CW'(CRC_STEPS - 1)) begin
                    state_d  = DONE;
                    dout_d   = {u_q, work_step[7:0]};
                    err_d    = 1'b0;
                    lut_wr_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any encode in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            din_q     <= 4'h0;
            poly_q    <= 8'h00;
            u_q       <= 8'h00;
            work_q    <= 16'h0000;
            polyreg_q <= 16'h0000;
            dout_q    <= 16'h0000;
            err_q     <= 1'b0;
            lut_wr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            din_q     <= din_d;
            poly_q    <= poly_d;
            u_q       <= u_d;
            work_q    <= work_d;
            polyreg_q <= polyreg_d;
            dout_q    <= dout_d;
            err_q     <= err_d;
            lut_wr_q  <= lut_wr_d;
        end
    end

    // in_ready is qualified by rst_n so it reads low while reset is held.
    assign in_ready  = rst_n && (state_q == IDLE) && en;
    assign out_valid = (state_q == DONE);
    assign dout      = dout_q;
    assign err       = err_q;
    assign lut_wr    = lut_wr_q;

endmodule
